store_buffer: RTL

- Sits between the MEM1 stage, which produces store_req_t, and the dcache write port.
- Holds speculative stores from MEM1, marks them committed as WB retires store instructions, and drains committed stores in order to the dcache with a valid/ready handshake.
- Gives MEM1 loads byte-granular store-to-load forwarding across all buffered entries.

---
 rtl/store_buffer.sv | 111 +++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer between MEM1 and the dcache write port: in-order drain of
// committed stores plus byte-granular store-to-load forwarding.
module store_buffer #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    st_valid_i,
    input  logic [DATA_WIDTH/8-1:0] st_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   st_waddr_i,
    input  logic [DATA_WIDTH-1:0]   st_wdata_i,
    output logic                    st_ready_o,
    input  logic [1:0]              commit_cnt_i,
    input  logic                    flush_i,
    output logic                    dc_valid_o,
    output logic [ADDR_WIDTH-1:0]   dc_waddr_o,
    output logic [DATA_WIDTH-1:0]   dc_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dc_wstrb_o,
    input  logic                    dc_ready_i,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr_i,
    output logic                    fwd_hit_o,
    output logic [DATA_WIDTH/8-1:0] fwd_strb_o,
    output logic [DATA_WIDTH-1:0]   fwd_data_o,
    output logic                    empty_o,
    output logic                    full_o
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [PW-1:0] n_valid;
    logic          enq, deq;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;
    logic [DEPTH-1:0][SW-1:0]         strb_q;

    logic [IW-1:0]         fidx;
    logic [SW-1:0]         fstrb;
    logic [DATA_WIDTH-1:0] fdata;
    logic                  unused_fwd_lsb;

    assign n_valid    = tail_q - head_q;
    assign empty_o    = (tail_q == head_q);
    assign full_o     = (tail_q[IW-1:0] == head_q[IW-1:0]) && (tail_q[IW] != head_q[IW]);
    assign st_ready_o = !full_o;
    assign dc_valid_o = (cmt_q != head_q);
    assign enq        = st_valid_i && st_ready_o && !flush_i;
    assign deq        = dc_valid_o && dc_ready_i;

    // Head fields are zeroed when nothing is committed so that reset and idle
    // present clean values regardless of stale array contents.
    assign dc_waddr_o = dc_valid_o ? addr_q[head_q[IW-1:0]] : '0;
    assign dc_wdata_o = dc_valid_o ? data_q[head_q[IW-1:0]] : '0;
    assign dc_wstrb_o = dc_valid_o ? strb_q[head_q[IW-1:0]] : '0;

    always_comb begin
        head_d = head_q + PW'(deq);
        cmt_d  = cmt_q + PW'(commit_cnt_i);
        // Flush trims back to the commit point after this cycle's retirements.
        tail_d = flush_i ? cmt_d : tail_q + PW'(enq);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            cmt_q  <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            cmt_q  <= cmt_d;
            tail_q <= tail_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q[IW-1:0]] <= st_waddr_i;
            data_q[tail_q[IW-1:0]] <= st_wdata_i;
            strb_q[tail_q[IW-1:0]] <= st_wstrb_i;
        end
    end

    // Walk entries oldest to youngest so younger matches overwrite per lane.
    always_comb begin
        fstrb = '0;
        fdata = '0;
        fidx  = '0;
        for (int a = 0; a < DEPTH; a++) begin
            fidx = head_q[IW-1:0] + IW'(a);
            if ((PW'(a) < n_valid) &&
                (addr_q[fidx][ADDR_WIDTH-1:2] == fwd_addr_i[ADDR_WIDTH-1:2])) begin
                for (int b = 0; b < SW; b++) begin
                    if (strb_q[fidx][b]) begin
                        fstrb[b]         = 1'b1;
                        fdata[b*8 +: 8] = data_q[fidx][b*8 +: 8];
                    end
                end
            end
        end
    end

    assign fwd_strb_o     = fstrb;
    assign fwd_data_o     = fdata;
    assign fwd_hit_o      = |fstrb;
    assign unused_fwd_lsb = ^fwd_addr_i[1:0];

endmodule
